// File: rtl/qtable_maxq_reader.sv
// Scans the 2**ACTION_WIDTH Q-values of one state and returns the largest (IEEE-754 ordered) and its action.
// Result appears 2**ACTION_WIDTH+2 cycles after accept and is held until i_rsp_ready; requests stall (o_req_ready low) while busy.
module qtable_maxq_reader #(
    parameter int ADDR_WIDTH   = 9,
    parameter int DATA_WIDTH   = 32,
    parameter int STATE_WIDTH  = 6,
    parameter int ACTION_WIDTH = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_req_valid,
    output logic                    o_req_ready,
    input  logic [STATE_WIDTH-1:0]  i_state,
    output logic                    o_rsp_valid,
    input  logic                    i_rsp_ready,
    output logic [DATA_WIDTH-1:0]   o_max_q,
    output logic [ACTION_WIDTH-1:0] o_max_action,
    input  logic                    i_wr_en,
    input  logic [ADDR_WIDTH-1:0]   i_wr_addr,
    input  logic [DATA_WIDTH-1:0]   i_wr_data,
    output logic                    o_mem_read_en,
    output logic [ADDR_WIDTH-1:0]   o_mem_addr_r,
    input  logic [DATA_WIDTH-1:0]   i_mem_data,
    output logic                    o_mem_write_en,
    output logic [ADDR_WIDTH-1:0]   o_mem_addr_w,
    output logic [DATA_WIDTH-1:0]   o_mem_data
);

    localparam int EXP_W   = 8;
    localparam int MAN_W   = DATA_WIDTH - 1 - EXP_W;
    localparam int NUM_ACT = 1 << ACTION_WIDTH;
    localparam logic [ACTION_WIDTH-1:0] LAST_ACT = ACTION_WIDTH'(NUM_ACT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_RESP  = 2'd3
    } fsm_t;

    fsm_t                    r_fsm;
    fsm_t                    w_fsm_nxt;
    logic [STATE_WIDTH-1:0]  r_state_idx;
    logic [ACTION_WIDTH-1:0] r_cnt;
    logic [ACTION_WIDTH-1:0] r_cap_act;
    logic [ACTION_WIDTH-1:0] r_max_act;
    logic                    r_cap_vld;
    logic                    r_fwd;
    logic [DATA_WIDTH-1:0]   r_fwd_dat;
    logic [DATA_WIDTH-1:0]   r_max_q;
    logic [DATA_WIDTH-1:0]   w_cand;
    logic [ADDR_WIDTH-1:0]   w_addr_r;
    logic                    w_accept;
    logic                    w_rd_en;
    logic                    w_fwd_hit;
    logic                    w_take;

    // Strict IEEE ordered greater-than: any NaN compares false, +0 equals -0.
    function automatic logic fp_gt(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
        logic a_nan, b_nan, a_zero, b_zero;
        a_nan  = (a[DATA_WIDTH-2:MAN_W] == '1) && (a[MAN_W-1:0] != '0);
        b_nan  = (b[DATA_WIDTH-2:MAN_W] == '1) && (b[MAN_W-1:0] != '0);
        a_zero = (a[DATA_WIDTH-2:0] == '0);
        b_zero = (b[DATA_WIDTH-2:0] == '0);
        if (a_nan || b_nan || (a_zero && b_zero))
            return 1'b0;
        else if (a[DATA_WIDTH-1] != b[DATA_WIDTH-1])
            return b[DATA_WIDTH-1];
        else if (!a[DATA_WIDTH-1])
            return a[DATA_WIDTH-2:0] > b[DATA_WIDTH-2:0];
        else
            return a[DATA_WIDTH-2:0] < b[DATA_WIDTH-2:0];
    endfunction

    assign o_mem_write_en = i_wr_en;
    assign o_mem_addr_w   = i_wr_addr;
    assign o_mem_data     = i_wr_data;

    assign w_addr_r     = ADDR_WIDTH'({r_state_idx, r_cnt});
    assign o_mem_addr_r = w_addr_r;
    assign o_mem_read_en = w_rd_en;
    assign o_max_q      = r_max_q;
    assign o_max_action = r_max_act;

    always_comb begin
        w_fsm_nxt   = r_fsm;
        o_req_ready = 1'b0;
        o_rsp_valid = 1'b0;
        w_rd_en     = 1'b0;
        w_accept    = 1'b0;
        case (r_fsm)
            ST_IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) begin
                    w_accept  = 1'b1;
                    w_fsm_nxt = ST_READ;
                end
            end
            ST_READ: begin
                w_rd_en = 1'b1;
                if (r_cnt == LAST_ACT)
                    w_fsm_nxt = ST_DRAIN;
            end
            ST_DRAIN: w_fsm_nxt = ST_RESP;
            ST_RESP: begin
                o_rsp_valid = 1'b1;
                if (i_rsp_ready)
                    w_fsm_nxt = ST_IDLE;
            end
            default: w_fsm_nxt = ST_IDLE;
        endcase
    end

    // A write landing on the address being read this cycle wins over the table's stale read data.
    assign w_fwd_hit = w_rd_en && i_wr_en && (i_wr_addr == w_addr_r);
    assign w_cand    = r_fwd ? r_fwd_dat : i_mem_data;
    assign w_take    = r_cap_vld && ((r_cap_act == '0) || fp_gt(w_cand, r_max_q));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fsm       <= ST_IDLE;
            r_state_idx <= '0;
            r_cnt       <= '0;
            r_cap_vld   <= 1'b0;
            r_cap_act   <= '0;
            r_fwd       <= 1'b0;
            r_fwd_dat   <= '0;
            r_max_q     <= '0;
            r_max_act   <= '0;
        end else begin
            r_fsm <= w_fsm_nxt;
            if (w_accept) begin
                r_state_idx <= i_state;
                r_cnt       <= '0;
            end else if (w_rd_en) begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_cap_vld <= w_rd_en;
            r_cap_act <= r_cnt;
            r_fwd     <= w_fwd_hit;
            r_fwd_dat <= i_wr_data;
            if (w_take) begin
                r_max_q   <= w_cand;
                r_max_act <= r_cap_act;
            end
        end
    end

endmodule
